rod_group_move: RTL and testbench
=================================

Name: rod_group_move

Overview:
- Parametrised successor to the per-frame rod mover: one foosball rod carrying NUM_PLAYERS figures at fixed vertical spacing.
- Adds velocity ramping (accelerate/cruise/brake), parametrised bounds, bound-hit reporting and a freeze input.
- Sits between the keypad decoders and the player drawing objects; updates once per video frame on startOfFrame.

Parameters:
- NUM_PLAYERS, 3, figures on the rod (1..4).
- PLAYER_SPACING, 160, Y offset between adjacent figures, pixels.
- INIT_Y, 32, reset top-left Y of figure 0.
- MIN_Y, -25, lowest legal top-left Y of figure 0.
- MAX_Y, 88, highest legal top-left Y of figure 0.
- MAX_SPEED, 8, velocity magnitude limit, pixels/frame (1..31).
- ACCEL, 2, velocity step per frame while a key is held.
- DECEL, 2, velocity step per frame while braking.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle frame strobe.
- hold  in  1  freeze: while 1, frame strobes are ignored.
- keyUpIsPressed  in  1  move toward MIN_Y.
- keyDownIsPressed  in  1  move toward MAX_Y.
- rodY  out  11 signed  top-left Y of figure 0.
- playerY  out  NUM_PLAYERS*11  packed signed Y; slice i = rodY + i*PLAYER_SPACING.
- velocity  out  6 signed  current velocity, pixels/frame.
- atTop  out  1  rodY == MIN_Y.
- atBottom  out  1  rodY == MAX_Y.
- hitPulse  out  1  one-cycle pulse when a frame update is clamped at a bound with nonzero velocity.

Behaviour:
- Reset (sync, clk edge with reset=1): state IDLE, velocity 0, rodY INIT_Y, playerY[i] = INIT_Y + i*PLAYER_SPACING, hitPulse 0, atTop/atBottom from INIT_Y. Reset wins over everything, including mid-motion.
- Update event: startOfFrame=1 and hold=0. All outputs are registered; new values are visible the cycle after the strobe. There are no changes between events. hitPulse is high only in that one cycle.
- Key decode: up = keyUp & ~keyDown; down = keyDown & ~keyUp. Both pressed or neither pressed = no drive.
- FSM, evaluated per event:
  - IDLE (v=0): up -> UP, v=-ACCEL; down -> DOWN, v=+ACCEL; otherwise stay.
  - UP: up -> v = max(v-ACCEL, -MAX_SPEED); otherwise -> BRAKE.
  - DOWN: down -> v = min(v+ACCEL, MAX_SPEED); otherwise -> BRAKE.
  - BRAKE: |v| reduced by DECEL, saturating at 0. Reaching 0 -> IDLE in the same event. Keys are ignored, so a reversal always passes through IDLE.
- Position: newY = rodY + v_new, where v_new is the velocity computed in the same event. Compute in 13-bit signed.
  - newY <= MIN_Y: rodY=MIN_Y, v=0, state IDLE; hitPulse=1 if v_new != 0.
  - newY >= MAX_Y: rodY=MAX_Y, v=0, state IDLE; hitPulse=1 if v_new != 0.
  - Otherwise rodY=newY.
- playerY slices and atTop/atBottom are updated in the same cycle as rodY. They are never one cycle stale.
- Elaboration error if MIN_Y > INIT_Y, INIT_Y > MAX_Y, MAX_SPEED > 31, or ACCEL/DECEL = 0.

Optional Feature:
- Macro ROD_BOUNCE_EN.
- Defined: at a bound clamp, v = -(v_new >>> 1) (arithmetic) and state becomes BRAKE. If the result is 0, state becomes IDLE. hitPulse is unchanged.
- Undefined: clamp zeroes velocity and enters IDLE, as above.

Test Plan:
- Reset: assert reset one cycle -> rodY=32, playerY={352,192,32}, velocity=0, atTop=0, atBottom=0, hitPulse=0.
- Ramp: keyDown held 6 frames from reset -> velocity 2,4,6,8,8,8; rodY 34,38,44,52,60,68.
- Brake: release keys after the ramp -> velocity 6,4,2,0; rodY 74,78,80,80; IDLE after the 4th frame. Pressing keyUp during BRAKE has no effect until IDLE.
- Bound: keyDown held 9 frames from reset -> rodY ...,84, then 88 on frame 9. hitPulse one cycle, atBottom=1, velocity=0. With ROD_BOUNCE_EN: velocity=-4, state BRAKE.
- Conflicts: both keys from IDLE -> no change. Both keys during DOWN at v=6 -> BRAKE, v=4.
- Freeze/reset: hold=1 with strobes and keyUp for 5 frames -> all outputs unchanged. reset asserted mid-ramp at rodY=52 -> rodY=32, velocity=0 next cycle.

Source files
------------

// File: rtl/rod_group_move.sv
// Foosball rod mover: NUM_PLAYERS figures with velocity ramp, bound clamp and freeze.
// Define ROD_BOUNCE_EN to make a bound clamp reverse at half speed instead of stopping.
//
// state | meaning
// IDLE  | at rest, velocity 0, waiting for a key
// UP    | accelerating/cruising toward MIN_Y
// DOWN  | accelerating/cruising toward MAX_Y
// BRAKE | decelerating to 0, keys ignored
module rod_group_move #(
  parameter int NUM_PLAYERS    = 3,
  parameter int PLAYER_SPACING = 160,
  parameter int INIT_Y         = 32,
  parameter int MIN_Y          = -25,
  parameter int MAX_Y          = 88,
  parameter int MAX_SPEED      = 8,
  parameter int ACCEL          = 2,
  parameter int DECEL          = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic                       hold,
  input  logic                       keyUpIsPressed,
  input  logic                       keyDownIsPressed,
  output logic signed [10:0]         rodY,
  output logic [NUM_PLAYERS*11-1:0]  playerY,
  output logic signed [5:0]          velocity,
  output logic                       atTop,
  output logic                       atBottom,
  output logic                       hitPulse
);

  if (MIN_Y > INIT_Y || INIT_Y > MAX_Y || MAX_SPEED > 31 || MAX_SPEED < 1 ||
      ACCEL == 0 || DECEL == 0 || NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_params
    $error("rod_group_move: illegal parameter combination");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] UP    = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] BRAKE = 2'd3;

  localparam logic signed [12:0] MIN13  = 13'(MIN_Y);
  localparam logic signed [12:0] MAX13  = 13'(MAX_Y);
  localparam logic signed [12:0] SPD13  = 13'(MAX_SPEED);
  localparam logic signed [12:0] ACC13  = 13'(ACCEL);
  localparam logic signed [12:0] DEC13  = 13'(DECEL);
  localparam logic signed [10:0] INIT11 = 11'(INIT_Y);
  localparam logic signed [10:0] MIN11  = 11'(MIN_Y);
  localparam logic signed [10:0] MAX11  = 11'(MAX_Y);

  logic [1:0]                state, state_nxt;
  logic                      up, down, frame_evt, hit_nxt;
  logic signed [12:0]        v_cur, rod_cur, v_brk, v_acc, v_calc, new_y;
  logic signed [5:0]         v_new6, v_fin;
  logic signed [10:0]        rod_nxt, rod_load;
  logic [NUM_PLAYERS*11-1:0] player_load;

  assign up        = keyUpIsPressed & ~keyDownIsPressed;
  assign down      = keyDownIsPressed & ~keyUpIsPressed;
  assign frame_evt = startOfFrame & ~hold;

  always_comb begin
    v_cur   = {{7{velocity[5]}}, velocity};
    rod_cur = {{2{rodY[10]}}, rodY};
    state_nxt = state;
    v_calc    = v_cur;
    v_acc     = 13'sd0;
    if (v_cur > DEC13)       v_brk = v_cur - DEC13;
    else if (v_cur < -DEC13) v_brk = v_cur + DEC13;
    else                     v_brk = 13'sd0;
    case (state)
      IDLE: begin
        if (up)        begin state_nxt = UP;   v_calc = -ACC13; end
        else if (down) begin state_nxt = DOWN; v_calc = ACC13;  end
      end
      UP: begin
        v_acc = v_cur - ACC13;
        if (up) v_calc = (v_acc < -SPD13) ? -SPD13 : v_acc;
        else begin
          v_calc    = v_brk;
          state_nxt = (v_brk == 13'sd0) ? IDLE : BRAKE;
        end
      end
      DOWN: begin
        v_acc = v_cur + ACC13;
        if (down) v_calc = (v_acc > SPD13) ? SPD13 : v_acc;
        else begin
          v_calc    = v_brk;
          state_nxt = (v_brk == 13'sd0) ? IDLE : BRAKE;
        end
      end
      default: begin
        v_calc    = v_brk;
        state_nxt = (v_brk == 13'sd0) ? IDLE : BRAKE;
      end
    endcase

    v_new6  = v_calc[5:0];
    v_fin   = v_new6;
    new_y   = rod_cur + v_calc;
    rod_nxt = new_y[10:0];
    hit_nxt = 1'b0;
    if (new_y <= MIN13 || new_y >= MAX13) begin
      rod_nxt = (new_y <= MIN13) ? MIN11 : MAX11;
      hit_nxt = (v_calc != 13'sd0);
`ifdef ROD_BOUNCE_EN
      // Half-speed rebound, then the normal brake sequence bleeds it off.
      v_fin     = -(v_new6 >>> 1);
      state_nxt = (v_fin == 6'sd0) ? IDLE : BRAKE;
`else
      v_fin     = 6'sd0;
      state_nxt = IDLE;
`endif
    end

    // Figure positions derive from the value about to be loaded into rodY.
    rod_load    = reset ? INIT11 : rod_nxt;
    player_load = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      player_load[i*11 +: 11] = rod_load + 11'(i * PLAYER_SPACING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      velocity <= 6'sd0;
      rodY     <= rod_load;
      playerY  <= player_load;
      atTop    <= (rod_load == MIN11);
      atBottom <= (rod_load == MAX11);
      hitPulse <= 1'b0;
    end else if (frame_evt) begin
      state    <= state_nxt;
      velocity <= v_fin;
      rodY     <= rod_load;
      playerY  <= player_load;
      atTop    <= (rod_load == MIN11);
      atBottom <= (rod_load == MAX11);
      hitPulse <= hit_nxt;
    end else begin
      hitPulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rod_group_move.sv
// Scoreboard bench for rod_group_move: a frame-level model pushes expected outputs,
// which are popped and compared after each strobe and again one quiet cycle later.
module tb_rod_group_move;
  localparam int NP  = 3;
  localparam int SP  = 160;
  localparam int IY  = 32;
  localparam int MNY = -25;
  localparam int MXY = 88;
  localparam int MS  = 8;
  localparam int AC  = 2;
  localparam int DC  = 2;

  logic clk = 1'b0;
  logic reset, startOfFrame, hold, keyUpIsPressed, keyDownIsPressed;
  logic signed [10:0] rodY;
  logic [NP*11-1:0]   playerY;
  logic signed [5:0]  velocity;
  logic atTop, atBottom, hitPulse;

  rod_group_move #(.NUM_PLAYERS(NP), .PLAYER_SPACING(SP), .INIT_Y(IY), .MIN_Y(MNY),
                   .MAX_Y(MXY), .MAX_SPEED(MS), .ACCEL(AC), .DECEL(DC)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hold(hold),
    .keyUpIsPressed(keyUpIsPressed), .keyDownIsPressed(keyDownIsPressed),
    .rodY(rodY), .playerY(playerY), .velocity(velocity),
    .atTop(atTop), .atBottom(atBottom), .hitPulse(hitPulse));

  always #5 clk = ~clk;

  typedef struct { int rod; int vel; int top; int bot; int hit; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_s, m_v, m_y, m_hit;   // model state: 0 idle, 1 up, 2 down, 3 brake

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.rod = m_y; e.vel = m_v; e.top = (m_y == MNY); e.bot = (m_y == MXY); e.hit = m_hit;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check_val({tag, "_rodY"}, int'(rodY), e.rod);
    check_val({tag, "_vel"}, int'(velocity), e.vel);
    check_val({tag, "_atTop"}, int'(atTop), e.top);
    check_val({tag, "_atBot"}, int'(atBottom), e.bot);
    check_val({tag, "_hit"}, int'(hitPulse), e.hit);
    for (int i = 0; i < NP; i++)
      check_val({tag, "_player"}, int'($signed(playerY[i*11 +: 11])), e.rod + i*SP);
  endtask

  task automatic model_frame(input bit ku, input bit kd);
    bit u, d;
    int brk, ns, nv, ny;
    u = ku && !kd;
    d = kd && !ku;
    brk = (m_v > DC) ? m_v - DC : (m_v < -DC) ? m_v + DC : 0;
    ns = m_s; nv = m_v;
    case (m_s)
      0: if (u) begin ns = 1; nv = -AC; end else if (d) begin ns = 2; nv = AC; end
      1: if (u) nv = (m_v - AC < -MS) ? -MS : m_v - AC;
         else begin nv = brk; ns = (brk == 0) ? 0 : 3; end
      2: if (d) nv = (m_v + AC > MS) ? MS : m_v + AC;
         else begin nv = brk; ns = (brk == 0) ? 0 : 3; end
      default: begin nv = brk; ns = (brk == 0) ? 0 : 3; end
    endcase
    ny = m_y + nv;
    m_hit = 0;
    if (ny <= MNY || ny >= MXY) begin
      ny = (ny <= MNY) ? MNY : MXY;
      m_hit = (nv != 0);
`ifdef ROD_BOUNCE_EN
      nv = -(nv >>> 1);
      ns = (nv == 0) ? 0 : 3;
`else
      nv = 0;
      ns = 0;
`endif
    end
    m_s = ns; m_v = nv; m_y = ny;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; startOfFrame = 1'b1; keyDownIsPressed = 1'b1; keyUpIsPressed = 1'b0; hold = 1'b0;
    m_s = 0; m_v = 0; m_y = IY; m_hit = 0;
    push_expect();
    @(posedge clk); #1;
    reset = 1'b0; startOfFrame = 1'b0; keyDownIsPressed = 1'b0;
    check_out("reset");
  endtask

  // One strobe, then a quiet cycle where nothing may change and hitPulse must be low.
  task automatic do_frame(input bit ku, input bit kd, input bit h);
    @(negedge clk);
    keyUpIsPressed = ku; keyDownIsPressed = kd; hold = h; startOfFrame = 1'b1;
    if (!h) model_frame(ku, kd);
    else m_hit = 0;
    push_expect();
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    check_out("frame");
    m_hit = 0;
    push_expect();
    @(posedge clk); #1;
    check_out("quiet");
  endtask

  int ramp_v[6] = '{2, 4, 6, 8, 8, 8};
  int ramp_y[6] = '{34, 38, 44, 52, 60, 68};
  int brk_v[4]  = '{6, 4, 2, 0};
  int brk_y[4]  = '{74, 78, 80, 80};

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; hold = 1'b0;
    keyUpIsPressed = 1'b0; keyDownIsPressed = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    check_val("reset_p0", int'($signed(playerY[10:0])), 32);
    check_val("reset_p1", int'($signed(playerY[21:11])), 192);
    check_val("reset_p2", int'($signed(playerY[32:22])), 352);

    for (int k = 0; k < 6; k++) begin
      do_frame(1'b0, 1'b1, 1'b0);
      check_val("ramp_v", int'(velocity), ramp_v[k]);
      check_val("ramp_y", int'(rodY), ramp_y[k]);
    end
    for (int k = 0; k < 4; k++) begin
      do_frame(1'b0, 1'b0, 1'b0);
      check_val("brake_v", int'(velocity), brk_v[k]);
      check_val("brake_y", int'(rodY), brk_y[k]);
    end

    // keyUp during BRAKE is ignored; takes effect only once back at IDLE.
    do_reset();
    repeat (4) do_frame(1'b0, 1'b1, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0);
    check_val("brake_up_v", int'(velocity), 6);
    check_val("brake_up_y", int'(rodY), 58);
    repeat (3) do_frame(1'b1, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0);
    check_val("idle_up_v", int'(velocity), -2);

    // Bottom bound.
    do_reset();
    repeat (9) do_frame(1'b0, 1'b1, 1'b0);
    check_val("bound_y", int'(rodY), 88);
    check_val("bound_atBottom", int'(atBottom), 1);
`ifdef ROD_BOUNCE_EN
    check_val("bound_v", int'(velocity), -4);
`else
    check_val("bound_v", int'(velocity), 0);
`endif
    repeat (3) do_frame(1'b0, 1'b0, 1'b0);

    // Top bound.
    do_reset();
    repeat (10) do_frame(1'b1, 1'b0, 1'b0);
    check_val("top_y", int'(rodY), MNY);
    repeat (3) do_frame(1'b0, 1'b0, 1'b0);

    // Conflicting keys.
    do_reset();
    do_frame(1'b1, 1'b1, 1'b0);
    check_val("both_idle_y", int'(rodY), 32);
    repeat (3) do_frame(1'b0, 1'b1, 1'b0);
    do_frame(1'b1, 1'b1, 1'b0);
    check_val("both_down_v", int'(velocity), 4);
    check_val("both_down_y", int'(rodY), 48);

    // Freeze, then reset mid-ramp.
    do_reset();
    repeat (4) do_frame(1'b0, 1'b1, 1'b0);
    repeat (5) do_frame(1'b1, 1'b0, 1'b1);
    check_val("hold_y", int'(rodY), 52);
    do_reset();
    check_val("midreset_y", int'(rodY), 32);
    check_val("midreset_v", int'(velocity), 0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 40) == 0) do_reset();
      else do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
